// File: rtl/ft245_pkg.sv
// Shared constants and state encoding for the FT245 device-side link.
package ft245_pkg;
  localparam int FT_DATA_W       = 8;
  localparam int DEF_DEPTH       = 16;
  localparam int DEF_GAP_CYCLES  = 2;
  localparam int DEF_SYNC_STAGES = 2;

  typedef enum logic [0:0] {
    ST_READY = 1'b0,
    ST_BUSY  = 1'b1
  } ft_state_e;
endpackage

// File: rtl/ft245_device_fifo.sv
// First-word-fall-through byte FIFO with registered count; push and pop may coincide at any fill.
module byte_fifo
  import ft245_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int W     = FT_DATA_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          do_push_s;
  logic          do_pop_s;

  assign empty     = (count_r == '0);
  assign full      = (count_r == CNT_FULL);
  assign do_pop_s  = pop & ~empty;
  assign do_push_s = push & (~full | do_pop_s);
  assign dout      = mem_r[rd_ptr_r];
  assign count     = count_r;

  // storage array, no reset needed
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // pointers wrap naturally at DEPTH
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end
endmodule

// File: rtl/synchronizer.sv
// Multi-flop synchronizer for a single asynchronous level input.
module synchronizer #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] sync_r;

  // shift the pin through the flop chain
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_r <= {STAGES{RST_VAL}};
    end else begin
      sync_r <= {sync_r[STAGES-2:0], d};
    end
  end

  assign q = sync_r[STAGES-1];
endmodule

// File: rtl/ft245_device.sv
// FTDI-side end of the FT245 async FIFO link: serves host RD#/WR# strobes from two byte FIFOs.
module ft245_device
  import ft245_pkg::*;
#(
  parameter int DEPTH       = DEF_DEPTH,
  parameter int GAP_CYCLES  = DEF_GAP_CYCLES,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ft_rd_n,
  input  logic                 ft_wr_n,
  input  logic [FT_DATA_W-1:0] ft_data_i,
  output logic [FT_DATA_W-1:0] ft_data_o,
  output logic                 ft_data_oe,
  output logic                 ft_rxf_n,
  output logic                 ft_txe_n,
  input  logic                 host_rx_valid,
  input  logic [FT_DATA_W-1:0] host_rx_data,
  output logic                 host_rx_ready,
  output logic                 host_tx_valid,
  output logic [FT_DATA_W-1:0] host_tx_data,
  input  logic                 host_tx_ready,
  output logic                 overrun,
  output logic                 underrun
);
  localparam int GW = $clog2(GAP_CYCLES + 2);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES);
  localparam logic [GW-1:0] GAP_ONE  = GW'(1);
  localparam int CW = $clog2(DEPTH) + 1;

  logic rd_sync_s, wr_sync_s;
  logic rd_prev_r, wr_prev_r;
  logic rd_rise_s, rd_fall_s, wr_fall_s;

  ft_state_e           rd_state_r, wr_state_r;
  logic [GW-1:0]       rd_gap_r, wr_gap_r;
  logic                rxf_n_r, txe_n_r;
  logic [FT_DATA_W-1:0] data_o_r;
  logic                overrun_r, underrun_r;

  logic                rx_push_s, rx_pop_s, rx_full_s, rx_empty_s;
  logic [FT_DATA_W-1:0] rx_dout_s;
  logic                tx_push_s, tx_pop_s, tx_full_s, tx_empty_s;
  logic [CW-1:0]       rx_count_s, tx_count_s;
  logic                unused_s;

  // Synchronizers reset to "strobe low" so a strobe held across reset release never looks like a new falling edge.
  synchronizer #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_rd_sync (
    .clk(clk), .reset(reset), .d(ft_rd_n), .q(rd_sync_s));
  synchronizer #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_wr_sync (
    .clk(clk), .reset(reset), .d(ft_wr_n), .q(wr_sync_s));

  // edge-detect registers for the synced strobes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_prev_r <= 1'b0;
      wr_prev_r <= 1'b0;
    end else begin
      rd_prev_r <= rd_sync_s;
      wr_prev_r <= wr_sync_s;
    end
  end

  assign rd_rise_s = rd_sync_s & ~rd_prev_r;
  assign rd_fall_s = ~rd_sync_s & rd_prev_r;
  assign wr_fall_s = ~wr_sync_s & wr_prev_r;

  assign rx_push_s = host_rx_valid & host_rx_ready;
  assign rx_pop_s  = rd_rise_s & (rd_state_r == ST_READY);
  assign tx_push_s = wr_fall_s & ~tx_full_s;
  assign tx_pop_s  = host_tx_ready & ~tx_empty_s;

  byte_fifo #(.DEPTH(DEPTH), .W(FT_DATA_W)) u_rx_fifo (
    .clk(clk), .reset(reset), .push(rx_push_s), .din(host_rx_data), .pop(rx_pop_s),
    .dout(rx_dout_s), .full(rx_full_s), .empty(rx_empty_s), .count(rx_count_s));
  byte_fifo #(.DEPTH(DEPTH), .W(FT_DATA_W)) u_tx_fifo (
    .clk(clk), .reset(reset), .push(tx_push_s), .din(ft_data_i), .pop(tx_pop_s),
    .dout(host_tx_data), .full(tx_full_s), .empty(tx_empty_s), .count(tx_count_s));

  assign unused_s = ^{rx_count_s, tx_count_s};

  // read-direction FSM: RXF# low in READY, high through strobe and gap
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_state_r <= ST_BUSY;
      rxf_n_r    <= 1'b1;
      rd_gap_r   <= GAP_LOAD;
      data_o_r   <= '0;
      underrun_r <= 1'b0;
    end else begin
      underrun_r <= rd_fall_s & rxf_n_r;
      case (rd_state_r)
        ST_READY: begin
          if (rd_rise_s) begin
            rd_state_r <= ST_BUSY;
            rxf_n_r    <= 1'b1;
            rd_gap_r   <= GAP_LOAD;
          end
        end
        ST_BUSY: begin
          if (!rd_sync_s) begin
            rd_gap_r <= GAP_LOAD;
          end else if (rd_gap_r != '0) begin
            rd_gap_r <= rd_gap_r - GAP_ONE;
          end else if (!rx_empty_s) begin
            rd_state_r <= ST_READY;
            rxf_n_r    <= 1'b0;
            data_o_r   <= rx_dout_s;
          end
        end
        default: begin
          rd_state_r <= ST_BUSY;
          rxf_n_r    <= 1'b1;
          rd_gap_r   <= GAP_LOAD;
        end
      endcase
    end
  end

  // write-direction FSM: every synced falling edge is served, even if the host ignored TXE#
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_state_r <= ST_BUSY;
      txe_n_r    <= 1'b1;
      wr_gap_r   <= GAP_LOAD;
      overrun_r  <= 1'b0;
    end else begin
      overrun_r <= wr_fall_s & tx_full_s;
      if (wr_fall_s) begin
        wr_state_r <= ST_BUSY;
        txe_n_r    <= 1'b1;
        wr_gap_r   <= GAP_LOAD;
      end else begin
        case (wr_state_r)
          ST_READY: wr_state_r <= ST_READY;
          ST_BUSY: begin
            if (!wr_sync_s) begin
              wr_gap_r <= GAP_LOAD;
            end else if (wr_gap_r != '0) begin
              wr_gap_r <= wr_gap_r - GAP_ONE;
            end else if (!tx_full_s) begin
              wr_state_r <= ST_READY;
              txe_n_r    <= 1'b0;
            end
          end
          default: begin
            wr_state_r <= ST_BUSY;
            txe_n_r    <= 1'b1;
            wr_gap_r   <= GAP_LOAD;
          end
        endcase
      end
    end
  end

  assign ft_data_o     = data_o_r;
  assign ft_data_oe    = ~ft_rd_n & ~reset;
  assign ft_rxf_n      = rxf_n_r;
  assign ft_txe_n      = txe_n_r;
  assign host_rx_ready = ~rx_full_s & ~reset;
  assign host_tx_valid = ~tx_empty_s;
  assign overrun       = overrun_r;
  assign underrun      = underrun_r;
endmodule

// File: tb/tb_ft245_device.sv
// Self-checking bench for ft245_device: vector table, scoreboard queues and corner-case sequences.
module tb_ft245_device;
  import ft245_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       ft_rd_n, ft_wr_n;
  logic [7:0] ft_data_i, ft_data_o;
  logic       ft_data_oe, ft_rxf_n, ft_txe_n;
  logic       host_rx_valid, host_rx_ready;
  logic [7:0] host_rx_data;
  logic       host_tx_valid, host_tx_ready;
  logic [7:0] host_tx_data;
  logic       overrun, underrun;

  always #5 clk = ~clk;

  ft245_device #(.DEPTH(16), .GAP_CYCLES(2), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .ft_rd_n(ft_rd_n), .ft_wr_n(ft_wr_n),
    .ft_data_i(ft_data_i), .ft_data_o(ft_data_o), .ft_data_oe(ft_data_oe),
    .ft_rxf_n(ft_rxf_n), .ft_txe_n(ft_txe_n),
    .host_rx_valid(host_rx_valid), .host_rx_data(host_rx_data), .host_rx_ready(host_rx_ready),
    .host_tx_valid(host_tx_valid), .host_tx_data(host_tx_data), .host_tx_ready(host_tx_ready),
    .overrun(overrun), .underrun(underrun));

  typedef struct {
    logic [7:0] rx_byte;
    logic [7:0] tx_byte;
    int         width;
  } vec_t;

  int         tests_run = 0;
  int         tests_failed = 0;
  int         ov_cnt = 0, un_cnt = 0, txv_cnt = 0;
  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];
  logic [7:0] last_rd = 8'h00;
  bit         wr_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    tests_run++;
    tests_failed++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // pulse counters and the host_tx scoreboard, sampled mid-cycle
  always @(negedge clk) begin
    if (!reset) begin
      if (overrun)       ov_cnt++;
      if (underrun)      un_cnt++;
      if (host_tx_valid) txv_cnt++;
      if (host_tx_valid && host_tx_ready) begin
        if (tx_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL tx_unexpected: got 0x%0h, expected no byte", host_tx_data);
        end else begin
          check("tx_data", {24'h0, host_tx_data}, {24'h0, tx_q.pop_front()});
        end
      end
    end
  end

  task automatic push_rx(input logic [7:0] b);
    int g = 0;
    host_rx_valid = 1'b1;
    host_rx_data  = b;
    while (!host_rx_ready && g < 1000) begin
      tick();
      g++;
    end
    if (!host_rx_ready) bound_fail("rx_push_wait");
    tick();
    rx_q.push_back(b);
    host_rx_valid = 1'b0;
  endtask

  task automatic host_read(input int w);
    int g = 0;
    logic [7:0] exp;
    while (ft_rxf_n && g < 1000) begin
      tick();
      g++;
    end
    if (ft_rxf_n) begin
      bound_fail("rxf_wait");
      return;
    end
    ft_rd_n = 1'b0;
    #1;
    check("data_oe_on", ft_data_oe, 1'b1);
    if (rx_q.size() == 0) begin
      bound_fail("rx_scoreboard_empty");
    end else begin
      exp = rx_q.pop_front();
      last_rd = exp;
      check("rd_data", ft_data_o, exp);
    end
    tick(w);
    ft_rd_n = 1'b1;
    #1;
    check("data_oe_off", ft_data_oe, 1'b0);
    tick(4);
    check("rxf_gap_a", ft_rxf_n, 1'b1);
    tick(1);
    check("rxf_gap_b", ft_rxf_n, 1'b1);
  endtask

  task automatic host_write(input logic [7:0] b, input int w, input bit force_it);
    int g = 0;
    if (!force_it) begin
      while (ft_txe_n && g < 1000) begin
        tick();
        g++;
      end
      if (ft_txe_n) begin
        bound_fail("txe_wait");
        return;
      end
    end
    ft_data_i = b;
    ft_wr_n   = 1'b0;
    tick(w);
    ft_wr_n = 1'b1;
    tick(3);
    check("txe_gap_a", ft_txe_n, 1'b1);
    tick(1);
    check("txe_gap_b", ft_txe_n, 1'b1);
  endtask

  task automatic wait_txe_low(input string name);
    int g = 0;
    while (ft_txe_n && g < 20) begin
      tick();
      g++;
    end
    check(name, ft_txe_n, 1'b0);
  endtask

  initial begin
    vec_t vecs[6];
    int   g, ov0, un0, txv0;
    vecs[0] = '{8'h01, 8'hFE, 4};
    vecs[1] = '{8'h80, 8'h7F, 5};
    vecs[2] = '{8'hFF, 8'h00, 6};
    vecs[3] = '{8'h55, 8'hAA, 4};
    vecs[4] = '{8'h00, 8'hFF, 5};
    vecs[5] = '{8'hC3, 8'h3C, 4};

    reset = 1'b1; ft_rd_n = 1'b1; ft_wr_n = 1'b1; ft_data_i = 8'h00;
    host_rx_valid = 1'b0; host_rx_data = 8'h00; host_tx_ready = 1'b0;
    tick(2);
    check("rst_rxf_n", ft_rxf_n, 1'b1);
    check("rst_txe_n", ft_txe_n, 1'b1);
    check("rst_data_o", ft_data_o, 8'h00);
    check("rst_tx_valid", host_tx_valid, 1'b0);
    check("rst_rx_ready", host_rx_ready, 1'b0);
    reset = 1'b0;
    tick(10);
    check("idle_rxf_n", ft_rxf_n, 1'b1);
    check("idle_txe_n", ft_txe_n, 1'b0);

    // 1: single device->host byte
    push_rx(8'hA5);
    g = 0;
    while (ft_rxf_n && g < 10) begin
      tick();
      g++;
    end
    check("rxf_latency", (g <= 2), 1'b1);
    host_read(4);
    tick(6);
    check("rxf_stays_high", ft_rxf_n, 1'b1);

    // 2: single host->device byte
    host_tx_ready = 1'b1;
    txv0 = txv_cnt;
    tx_q.push_back(8'h3C);
    host_write(8'h3C, 4, 1'b0);
    wait_txe_low("txe_returns");
    check("tx_valid_cycles", txv_cnt - txv0, 1);
    check("tx_q_drained_2", tx_q.size(), 0);

    // table vectors: one byte each way per record
    for (int i = 0; i < 6; i++) begin
      push_rx(vecs[i].rx_byte);
      host_read(vecs[i].width);
      tx_q.push_back(vecs[i].tx_byte);
      host_write(vecs[i].tx_byte, vecs[i].width, 1'b0);
      tick(3);
    end
    check("tbl_tx_drained", tx_q.size(), 0);

    // 3: fill TX with the consumer stalled, then overrun
    host_tx_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tx_q.push_back(8'(i * 13 + 7));
      host_write(8'(i * 13 + 7), 4, 1'b0);
    end
    tick(8);
    check("txe_full_high", ft_txe_n, 1'b1);
    ov0 = ov_cnt;
    host_write(8'hEE, 4, 1'b1);
    tick(2);
    check("overrun_pulse", ov_cnt - ov0, 1);
    host_tx_ready = 1'b1;
    tick(25);
    check("full_drained", tx_q.size(), 0);
    wait_txe_low("txe_after_drain");

    // 4: host read with nothing available
    un0 = un_cnt;
    ft_rd_n = 1'b0;
    tick(5);
    ft_rd_n = 1'b1;
    tick(6);
    check("underrun_pulse", un_cnt - un0, 1);
    check("underrun_data_hold", ft_data_o, last_rd);
    check("underrun_rxf", ft_rxf_n, 1'b1);
    push_rx(8'h5A);
    host_read(4);
    check("underrun_no_extra", un_cnt - un0, 1);

    // 5: reset in the middle of a write strobe
    txv0 = txv_cnt;
    ov0 = ov_cnt;
    ft_data_i = 8'h77;
    ft_wr_n = 1'b0;
    tick(1);
    reset = 1'b1;
    #1;
    check("mid_rst_rxf_n", ft_rxf_n, 1'b1);
    check("mid_rst_txe_n", ft_txe_n, 1'b1);
    check("mid_rst_oe", ft_data_oe, 1'b0);
    check("mid_rst_data_o", ft_data_o, 8'h00);
    check("mid_rst_tx_valid", host_tx_valid, 1'b0);
    check("mid_rst_pulses", {overrun, underrun}, 2'b00);
    tick(3);
    reset = 1'b0;
    tick(4);
    ft_wr_n = 1'b1;
    tick(3);
    check("post_rst_txe_gap", ft_txe_n, 1'b1);
    wait_txe_low("post_rst_txe_low");
    check("post_rst_no_push", txv_cnt - txv0, 0);
    check("post_rst_no_overrun", ov_cnt - ov0, 0);
    tick(5);

    // 6: concurrent random traffic in both directions
    ov0 = ov_cnt;
    un0 = un_cnt;
    wr_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 256; i++) begin
          push_rx(8'($urandom));
          tick($urandom_range(0, 3));
        end
      end
      begin
        for (int i = 0; i < 256; i++) host_read($urandom_range(4, 6));
      end
      begin
        logic [7:0] b;
        for (int i = 0; i < 256; i++) begin
          b = 8'($urandom);
          tx_q.push_back(b);
          host_write(b, $urandom_range(4, 6), 1'b0);
        end
        wr_done = 1'b1;
      end
      begin
        while (!wr_done) begin
          host_tx_ready = 1'($urandom_range(0, 1));
          tick();
        end
        host_tx_ready = 1'b1;
      end
    join
    tick(30);
    check("rand_tx_drained", tx_q.size(), 0);
    check("rand_rx_drained", rx_q.size(), 0);
    check("rand_no_overrun", ov_cnt - ov0, 0);
    check("rand_no_underrun", un_cnt - un0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
